// File: rtl/sc_game_sequencer.sv
// Game sequencer: paces lane traffic, tracks lives/level/score and requests game-over.
// Runs on the main 50 MHz clock beside the main game state machine.
module sc_game_sequencer #(
   parameter int unsigned PRESCALE      = 2500000,
   parameter int unsigned FREEZE_CYCLES = 50000000
) (
   input  logic       SC_MAIN_STATEMACHINE_CLOCK_50,
   input  logic       SC_MAIN_STATEMACHINE_RESET_InHigh,
   input  logic [1:0] MainState_In,
   input  logic       FrogHit_InLow,
   input  logic       FrogGoal_InLow,
   output logic [3:0] LaneTick_Out,
   output logic [1:0] Level_Out,
   output logic [1:0] Lives_Out,
   output logic [7:0] Score_Out,
   output logic       LevelUp_Out,
   output logic       EndGame_OutLow,
   output logic [2:0] SeqState_Out
);

   localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned FZ_W = (FREEZE_CYCLES > 1) ? $clog2(FREEZE_CYCLES) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [FZ_W-1:0] FZ_LAST = FZ_W'(FREEZE_CYCLES - 1);

   localparam logic [1:0] MS_AWAIT = 2'b00;
   localparam logic [1:0] MS_ACK   = 2'b11;
   localparam logic [1:0] MS_PLAY  = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_INIT   = 3'd1,
      ST_RUN    = 3'd2,
      ST_FREEZE = 3'd3,
      ST_OVER   = 3'd4
   } state_e;

   state_e            state_q;
   logic [PS_W-1:0]   ps_q;
   logic [PS_W-1:0]   ps_d;
   logic [FZ_W-1:0]   freeze_q;
   logic [3:0][2:0]   lane_cnt_q;
   logic [3:0][2:0]   lane_cnt_d;
   logic [3:0][2:0]   lane_last_s;
   logic [3:0]        lane_wrap_s;
   logic              base_tick_s;
   logic [1:0]        level_q;
   logic [1:0]        lives_q;
   logic [7:0]        score_q;
   logic [3:0]        lane_tick_q;
   logic              levelup_q;
   logic              endgame_q;
   logic              hit_s;
   logic              goal_s;
   logic              play_s;

   assign hit_s  = ~FrogHit_InLow;
   assign goal_s = ~FrogGoal_InLow;
   assign play_s = (MainState_In == MS_PLAY);

   // Prescaler and lane counter next values; they only move while in RUN.
   always_comb begin
      ps_d        = ps_q;
      base_tick_s = 1'b0;
      lane_cnt_d  = lane_cnt_q;
      lane_wrap_s = 4'b0000;
      if (state_q == ST_RUN) begin
         if (ps_q == PS_LAST) begin
            ps_d        = '0;
            base_tick_s = 1'b1;
         end else begin
            ps_d = ps_q + PS_W'(1);
         end
      end else begin
         ps_d = ps_q;
      end
      for (int i = 0; i < 4; i++) begin
         // Lane period is 4+i-Level base ticks; never below 1 because Level <= 3.
         lane_last_s[i] = 3'(4'd3 + 4'(i) - {2'b00, level_q});
         if (base_tick_s) begin
            if (lane_cnt_q[i] >= lane_last_s[i]) begin
               lane_cnt_d[i]  = 3'd0;
               lane_wrap_s[i] = 1'b1;
            end else begin
               lane_cnt_d[i] = lane_cnt_q[i] + 3'd1;
            end
         end else begin
            lane_cnt_d[i] = lane_cnt_q[i];
         end
      end
   end

   // Sequencer state machine with all game registers and registered outputs.
   always_ff @(posedge SC_MAIN_STATEMACHINE_CLOCK_50 or posedge SC_MAIN_STATEMACHINE_RESET_InHigh) begin
      if (SC_MAIN_STATEMACHINE_RESET_InHigh) begin
         state_q     <= ST_IDLE;
         ps_q        <= '0;
         freeze_q    <= '0;
         lane_cnt_q  <= '0;
         level_q     <= 2'd0;
         lives_q     <= 2'd3;
         score_q     <= 8'd0;
         lane_tick_q <= 4'b0000;
         levelup_q   <= 1'b0;
         endgame_q   <= 1'b1;
      end else begin
         lane_tick_q <= 4'b0000;
         levelup_q   <= 1'b0;
         ps_q        <= ps_d;
         lane_cnt_q  <= lane_cnt_d;
         case (state_q)
            ST_IDLE: begin
               endgame_q <= 1'b1;
               if (MainState_In == MS_ACK) begin
                  state_q <= ST_INIT;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_INIT: begin
               lives_q    <= 2'd3;
               level_q    <= 2'd0;
               score_q    <= 8'd0;
               ps_q       <= '0;
               lane_cnt_q <= '0;
               freeze_q   <= '0;
               endgame_q  <= 1'b1;
               state_q    <= ST_RUN;
            end
            ST_RUN: begin
               if (!play_s) begin
                  state_q <= ST_IDLE;
               end else if (hit_s) begin
                  // A hit wins over a simultaneous goal; the goal is simply dropped.
                  if (lives_q > 2'd1) begin
                     lives_q  <= lives_q - 2'd1;
                     freeze_q <= '0;
                     state_q  <= ST_FREEZE;
                  end else begin
                     lives_q   <= 2'd0;
                     endgame_q <= 1'b0;
                     state_q   <= ST_OVER;
                  end
               end else begin
                  lane_tick_q <= lane_wrap_s;
                  if (goal_s) begin
                     levelup_q <= 1'b1;
                     if (score_q != 8'd255) begin
                        score_q <= score_q + 8'd1;
                     end
                     if (level_q != 2'd3) begin
                        level_q <= level_q + 2'd1;
                     end
                  end
               end
            end
            ST_FREEZE: begin
               if (freeze_q == FZ_LAST) begin
                  freeze_q <= '0;
                  state_q  <= play_s ? ST_RUN : ST_IDLE;
               end else begin
                  freeze_q <= freeze_q + FZ_W'(1);
               end
            end
            ST_OVER: begin
               if (MainState_In == MS_AWAIT) begin
                  endgame_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end else begin
                  endgame_q <= 1'b0;
               end
            end
            default: begin
               endgame_q <= 1'b1;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign LaneTick_Out   = lane_tick_q;
   assign Level_Out      = level_q;
   assign Lives_Out      = lives_q;
   assign Score_Out      = score_q;
   assign LevelUp_Out    = levelup_q;
   assign EndGame_OutLow = endgame_q;
   assign SeqState_Out   = state_q;

endmodule

// File: tb/tb_sc_game_sequencer.sv
// Directed bench for sc_game_sequencer with PRESCALE=4 and FREEZE_CYCLES=8.
module tb_sc_game_sequencer;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic [1:0] ms     = 2'b00;
   logic       hit_n  = 1'b1;
   logic       goal_n = 1'b1;
   logic [3:0] lane_tick;
   logic [1:0] level;
   logic [1:0] lives;
   logic [7:0] score;
   logic       levelup;
   logic       endgame_n;
   logic [2:0] seq;
   int vec_cnt = 0;
   int err_cnt = 0;

   sc_game_sequencer #(.PRESCALE(4), .FREEZE_CYCLES(8)) dut (
      .SC_MAIN_STATEMACHINE_CLOCK_50     (clk),
      .SC_MAIN_STATEMACHINE_RESET_InHigh (rst),
      .MainState_In                      (ms),
      .FrogHit_InLow                     (hit_n),
      .FrogGoal_InLow                    (goal_n),
      .LaneTick_Out                      (lane_tick),
      .Level_Out                         (level),
      .Lives_Out                         (lives),
      .Score_Out                         (score),
      .LevelUp_Out                       (levelup),
      .EndGame_OutLow                    (endgame_n),
      .SeqState_Out                      (seq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; ms = 2'b00; hit_n = 1'b1; goal_n = 1'b1;
      repeat (3) tick();
      vec_cnt++; if (seq !== 3'd0) begin err_cnt++; $display("FAIL reset_state: got %0d expected 0", seq); end
      vec_cnt++; if (lives !== 2'd3) begin err_cnt++; $display("FAIL reset_lives: got %0d expected 3", lives); end
      vec_cnt++; if (level !== 2'd0) begin err_cnt++; $display("FAIL reset_level: got %0d expected 0", level); end
      vec_cnt++; if (score !== 8'd0) begin err_cnt++; $display("FAIL reset_score: got %0d expected 0", score); end
      vec_cnt++; if (lane_tick !== 4'd0) begin err_cnt++; $display("FAIL reset_lane: got %b expected 0000", lane_tick); end
      vec_cnt++; if (levelup !== 1'b0) begin err_cnt++; $display("FAIL reset_levelup: got %b expected 0", levelup); end
      vec_cnt++; if (endgame_n !== 1'b1) begin err_cnt++; $display("FAIL reset_endgame: got %b expected 1", endgame_n); end
      rst = 1'b0;
      tick();
      vec_cnt++; if (seq !== 3'd0) begin err_cnt++; $display("FAIL idle_hold: got %0d expected 0", seq); end
   endtask

   task automatic test_start();
      ms = 2'b11; tick();
      vec_cnt++; if (seq !== 3'd1) begin err_cnt++; $display("FAIL start_init: got %0d expected 1", seq); end
      ms = 2'b01; tick();
      vec_cnt++; if (seq !== 3'd2) begin err_cnt++; $display("FAIL start_run: got %0d expected 2", seq); end
      vec_cnt++; if (lives !== 2'd3) begin err_cnt++; $display("FAIL start_lives: got %0d expected 3", lives); end
      vec_cnt++; if (level !== 2'd0) begin err_cnt++; $display("FAIL start_level: got %0d expected 0", level); end
      vec_cnt++; if (score !== 8'd0) begin err_cnt++; $display("FAIL start_score: got %0d expected 0", score); end
   endtask

   // Level 0: lane i wraps every 4+i base ticks of 4 cycles; first pulse one cycle after the wrap tick.
   task automatic test_lane_level0();
      int first [4];
      int second [4];
      int cnt [4];
      for (int b = 0; b < 4; b++) begin first[b] = -1; second[b] = -1; cnt[b] = 0; end
      for (int s = 1; s <= 60; s++) begin
         tick();
         for (int b = 0; b < 4; b++) begin
            if (lane_tick[b]) begin
               if (first[b] < 0) first[b] = s;
               else if (second[b] < 0) second[b] = s;
               cnt[b]++;
            end
         end
      end
      vec_cnt++; if (first[0] !== 16) begin err_cnt++; $display("FAIL l0_lane0_first: got %0d expected 16", first[0]); end
      vec_cnt++; if (second[0] !== 32) begin err_cnt++; $display("FAIL l0_lane0_second: got %0d expected 32", second[0]); end
      vec_cnt++; if (cnt[0] !== 3) begin err_cnt++; $display("FAIL l0_lane0_width: got %0d expected 3", cnt[0]); end
      vec_cnt++; if (first[1] !== 20) begin err_cnt++; $display("FAIL l0_lane1_first: got %0d expected 20", first[1]); end
      vec_cnt++; if (first[2] !== 24) begin err_cnt++; $display("FAIL l0_lane2_first: got %0d expected 24", first[2]); end
      vec_cnt++; if (first[3] !== 28) begin err_cnt++; $display("FAIL l0_lane3_first: got %0d expected 28", first[3]); end
      vec_cnt++; if (second[3] !== 56) begin err_cnt++; $display("FAIL l0_lane3_second: got %0d expected 56", second[3]); end
      vec_cnt++; if (cnt[3] !== 2) begin err_cnt++; $display("FAIL l0_lane3_width: got %0d expected 2", cnt[3]); end
   endtask

   task automatic test_goals();
      logic [1:0] exp_level;
      for (int g = 1; g <= 4; g++) begin
         exp_level = (g > 3) ? 2'd3 : 2'(g);
         goal_n = 1'b0; tick(); goal_n = 1'b1;
         vec_cnt++; if (levelup !== 1'b1) begin err_cnt++; $display("FAIL goal%0d_pulse: got %b expected 1", g, levelup); end
         vec_cnt++; if (score !== 8'(g)) begin err_cnt++; $display("FAIL goal%0d_score: got %0d expected %0d", g, score, g); end
         vec_cnt++; if (level !== exp_level) begin err_cnt++; $display("FAIL goal%0d_level: got %0d expected %0d", g, level, exp_level); end
         tick();
         vec_cnt++; if (levelup !== 1'b0) begin err_cnt++; $display("FAIL goal%0d_pulse_end: got %b expected 0", g, levelup); end
      end
   endtask

   // Level 3: lane periods are 1, 2, 3, 4 base ticks, i.e. 4, 8, 12, 16 cycles.
   task automatic test_lane_level3();
      int first [4];
      int second [4];
      int cnt0;
      cnt0 = 0;
      for (int b = 0; b < 4; b++) begin first[b] = -1; second[b] = -1; end
      for (int s = 1; s <= 40; s++) begin
         tick();
         if (lane_tick[0]) cnt0++;
         for (int b = 0; b < 4; b++) begin
            if (lane_tick[b]) begin
               if (first[b] < 0) first[b] = s;
               else if (second[b] < 0) second[b] = s;
            end
         end
      end
      vec_cnt++; if (second[0] - first[0] !== 4) begin err_cnt++; $display("FAIL l3_lane0_period: got %0d expected 4", second[0] - first[0]); end
      vec_cnt++; if (cnt0 !== 10) begin err_cnt++; $display("FAIL l3_lane0_count: got %0d expected 10", cnt0); end
      vec_cnt++; if (second[1] - first[1] !== 8) begin err_cnt++; $display("FAIL l3_lane1_period: got %0d expected 8", second[1] - first[1]); end
      vec_cnt++; if (second[3] - first[3] !== 16) begin err_cnt++; $display("FAIL l3_lane3_period: got %0d expected 16", second[3] - first[3]); end
   endtask

   task automatic test_hit_goal_freeze();
      hit_n = 1'b0; goal_n = 1'b0; tick(); hit_n = 1'b1; goal_n = 1'b1;
      vec_cnt++; if (seq !== 3'd3) begin err_cnt++; $display("FAIL hg_state: got %0d expected 3", seq); end
      vec_cnt++; if (lives !== 2'd2) begin err_cnt++; $display("FAIL hg_lives: got %0d expected 2", lives); end
      vec_cnt++; if (score !== 8'd4) begin err_cnt++; $display("FAIL hg_score: got %0d expected 4", score); end
      vec_cnt++; if (levelup !== 1'b0) begin err_cnt++; $display("FAIL hg_levelup: got %b expected 0", levelup); end
      vec_cnt++; if (lane_tick !== 4'd0) begin err_cnt++; $display("FAIL hg_lane: got %b expected 0000", lane_tick); end
      for (int c = 1; c <= 7; c++) begin
         if (c == 3) hit_n = 1'b0;
         tick(); hit_n = 1'b1;
         vec_cnt++; if (seq !== 3'd3) begin err_cnt++; $display("FAIL freeze_state_c%0d: got %0d expected 3", c, seq); end
         vec_cnt++; if (lane_tick !== 4'd0) begin err_cnt++; $display("FAIL freeze_lane_c%0d: got %b expected 0000", c, lane_tick); end
      end
      vec_cnt++; if (lives !== 2'd2) begin err_cnt++; $display("FAIL freeze_hit_ignored: got %0d expected 2", lives); end
      tick();
      vec_cnt++; if (seq !== 3'd2) begin err_cnt++; $display("FAIL freeze_exit: got %0d expected 2", seq); end
   endtask

   task automatic test_game_over();
      hit_n = 1'b0; tick(); hit_n = 1'b1;
      vec_cnt++; if (lives !== 2'd1) begin err_cnt++; $display("FAIL over_hit2_lives: got %0d expected 1", lives); end
      vec_cnt++; if (seq !== 3'd3) begin err_cnt++; $display("FAIL over_hit2_state: got %0d expected 3", seq); end
      repeat (8) tick();
      vec_cnt++; if (seq !== 3'd2) begin err_cnt++; $display("FAIL over_rerun: got %0d expected 2", seq); end
      hit_n = 1'b0; tick(); hit_n = 1'b1;
      vec_cnt++; if (lives !== 2'd0) begin err_cnt++; $display("FAIL over_lives: got %0d expected 0", lives); end
      vec_cnt++; if (seq !== 3'd4) begin err_cnt++; $display("FAIL over_state: got %0d expected 4", seq); end
      vec_cnt++; if (endgame_n !== 1'b0) begin err_cnt++; $display("FAIL over_endgame: got %b expected 0", endgame_n); end
      repeat (3) tick();
      vec_cnt++; if (seq !== 3'd4) begin err_cnt++; $display("FAIL over_hold: got %0d expected 4", seq); end
      vec_cnt++; if (lane_tick !== 4'd0) begin err_cnt++; $display("FAIL over_lane: got %b expected 0000", lane_tick); end
      ms = 2'b00; tick();
      vec_cnt++; if (seq !== 3'd0) begin err_cnt++; $display("FAIL over_to_idle: got %0d expected 0", seq); end
      vec_cnt++; if (endgame_n !== 1'b1) begin err_cnt++; $display("FAIL idle_endgame: got %b expected 1", endgame_n); end
      vec_cnt++; if (score !== 8'd4) begin err_cnt++; $display("FAIL idle_score_held: got %0d expected 4", score); end
      vec_cnt++; if (level !== 2'd3) begin err_cnt++; $display("FAIL idle_level_held: got %0d expected 3", level); end
      vec_cnt++; if (lives !== 2'd0) begin err_cnt++; $display("FAIL idle_lives_held: got %0d expected 0", lives); end
   endtask

   task automatic test_reset_freeze();
      int seen;
      seen = 0;
      ms = 2'b11; tick(); ms = 2'b01; tick();
      vec_cnt++; if (score !== 8'd0) begin err_cnt++; $display("FAIL restart_score: got %0d expected 0", score); end
      goal_n = 1'b0; tick(); goal_n = 1'b1;
      vec_cnt++; if (score !== 8'd1) begin err_cnt++; $display("FAIL restart_goal: got %0d expected 1", score); end
      hit_n = 1'b0; tick(); hit_n = 1'b1;
      vec_cnt++; if (seq !== 3'd3) begin err_cnt++; $display("FAIL rf_freeze: got %0d expected 3", seq); end
      repeat (3) tick();
      #3 rst = 1'b1;
      #1;
      vec_cnt++; if (seq !== 3'd0) begin err_cnt++; $display("FAIL rf_state: got %0d expected 0", seq); end
      vec_cnt++; if (lives !== 2'd3) begin err_cnt++; $display("FAIL rf_lives: got %0d expected 3", lives); end
      vec_cnt++; if (level !== 2'd0) begin err_cnt++; $display("FAIL rf_level: got %0d expected 0", level); end
      vec_cnt++; if (score !== 8'd0) begin err_cnt++; $display("FAIL rf_score: got %0d expected 0", score); end
      vec_cnt++; if (endgame_n !== 1'b1) begin err_cnt++; $display("FAIL rf_endgame: got %b expected 1", endgame_n); end
      vec_cnt++; if (lane_tick !== 4'd0) begin err_cnt++; $display("FAIL rf_lane: got %b expected 0000", lane_tick); end
      tick(); rst = 1'b0;
      for (int s = 0; s < 40; s++) begin
         tick();
         if (lane_tick !== 4'd0 || levelup !== 1'b0) seen++;
      end
      vec_cnt++; if (seen !== 0) begin err_cnt++; $display("FAIL rf_no_pulse: got %0d pulses expected 0", seen); end
      vec_cnt++; if (seq !== 3'd0) begin err_cnt++; $display("FAIL rf_idle: got %0d expected 0", seq); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_lane_level0();
      test_goals();
      test_lane_level3();
      test_hit_goal_freeze();
      test_game_over();
      test_reset_freeze();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
